// File: rtl/matrix_pkg.sv
// Shared constants, index-width helper and FSM state type for the matrix ROM streamer.
package matrix_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned ROWS       = 32;
  localparam int unsigned COLS       = 32;
  localparam int unsigned ADDR_WIDTH = 10;
  localparam int unsigned FIFO_DEPTH = 4;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned ROW_WIDTH = idx_width(ROWS);
  localparam int unsigned COL_WIDTH = idx_width(COLS);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain
  } state_e;

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO with occupancy count; push while full is accepted only alongside a pop.
module stream_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CntW-1:0]  count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

endmodule

// File: rtl/matrix_rom_streamer.sv
// Scans a ROWS x COLS coefficient ROM and streams it out with row/col tags and a last flag.
// Define MATRIX_TRANSPOSE_EN for a column-major scan (downstream sees the transpose).
module matrix_rom_streamer #(
  parameter int unsigned DATA_WIDTH = matrix_pkg::DATA_WIDTH,
  parameter int unsigned ROWS       = matrix_pkg::ROWS,
  parameter int unsigned COLS       = matrix_pkg::COLS,
  parameter int unsigned ADDR_WIDTH = matrix_pkg::ADDR_WIDTH,
  localparam int unsigned RowW      = matrix_pkg::idx_width(ROWS),
  localparam int unsigned ColW      = matrix_pkg::idx_width(COLS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [RowW-1:0]       m_row,
  output logic [ColW-1:0]       m_col,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready
);

  import matrix_pkg::*;

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  state_e          state_q;
  logic [RowW-1:0] frow_q, frow_nxt, orow_q, orow_nxt;
  logic [ColW-1:0] fcol_q, fcol_nxt, ocol_q, ocol_nxt;
  logic            issue_q, rd_valid_q;
  logic [CntW-1:0] fifo_count;
  logic            fifo_empty, fifo_full;
  logic            credit, fetch_last, hs;
  logic [ADDR_WIDTH-1:0] fetch_addr;

  // Advance a (row, col) position one element along the scan order.
  function automatic logic [RowW+ColW-1:0] step(input logic [RowW-1:0] r,
                                                input logic [ColW-1:0] c);
    logic [RowW-1:0] rn;
    logic [ColW-1:0] cn;
    rn = r;
    cn = c;
`ifdef MATRIX_TRANSPOSE_EN
    if (r == RowW'(ROWS - 1)) begin
      rn = '0;
      cn = (c == ColW'(COLS - 1)) ? '0 : c + 1'b1;
    end else begin
      rn = r + 1'b1;
    end
`else
    if (c == ColW'(COLS - 1)) begin
      cn = '0;
      rn = (r == RowW'(ROWS - 1)) ? '0 : r + 1'b1;
    end else begin
      cn = c + 1'b1;
    end
`endif
    return {rn, cn};
  endfunction

  always_comb begin
    {frow_nxt, fcol_nxt} = step(frow_q, fcol_q);
    {orow_nxt, ocol_nxt} = step(orow_q, ocol_q);
  end

  assign fetch_addr = ADDR_WIDTH'(frow_nxt) * ADDR_WIDTH'(COLS) + ADDR_WIDTH'(fcol_nxt);
  assign fetch_last = (frow_nxt == RowW'(ROWS - 1)) && (fcol_nxt == ColW'(COLS - 1));

  // Registered counts only: a pop in this cycle does not free a slot until next cycle.
  assign credit = (32'(fifo_count) + 32'(issue_q) + 32'(rd_valid_q)) < FIFO_DEPTH;

  assign m_valid = !fifo_empty;
  assign hs      = m_valid && m_ready;
  assign busy    = (state_q != StIdle);
  assign m_row   = orow_q;
  assign m_col   = ocol_q;
  assign m_last  = (orow_q == RowW'(ROWS - 1)) && (ocol_q == ColW'(COLS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rom_addr <= '0;
      frow_q   <= '0;
      fcol_q   <= '0;
      issue_q  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done    <= 1'b0;
      issue_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= (ROWS * COLS == 1) ? StDrain : StFetch;
            rom_addr <= '0;
            frow_q   <= '0;
            fcol_q   <= '0;
            issue_q  <= 1'b1;
          end
        end
        StFetch: begin
          if (credit) begin
            frow_q   <= frow_nxt;
            fcol_q   <= fcol_nxt;
            rom_addr <= fetch_addr;
            issue_q  <= 1'b1;
            if (fetch_last) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (hs && m_last) begin
            state_q <= StIdle;
            done    <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Read pipeline flag and output-side position counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      orow_q     <= '0;
      ocol_q     <= '0;
    end else begin
      rd_valid_q <= issue_q;
      if (hs) begin
        orow_q <= orow_nxt;
        ocol_q <= ocol_nxt;
      end
    end
  end

  stream_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_valid_q),
    .wdata (rom_q),
    .pop   (hs),
    .rdata (m_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_matrix_rom_streamer.sv
// Directed bench for matrix_rom_streamer with a behavioural synchronous ROM (q = addr[7:0]).
module tb_matrix_rom_streamer;

  localparam int ROWS = 32;
  localparam int COLS = 32;
  localparam int N    = ROWS * COLS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done;
  logic [9:0] rom_addr;
  logic [7:0] rom_q;
  logic [7:0] m_data;
  logic [4:0] m_row;
  logic [4:0] m_col;
  logic       m_last, m_valid;
  logic       m_ready = 1'b0;

  int         n_cmp = 0;
  int         n_mis = 0;
  int         dones = 0;
  logic [15:0] lfsr = 16'hACE1;
  int         cyc;

  always #5 clk = ~clk;

  always_ff @(posedge clk) rom_q <= rom_addr[7:0];

  matrix_rom_streamer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rom_addr (rom_addr),
    .rom_q    (rom_q),
    .m_data   (m_data),
    .m_row    (m_row),
    .m_col    (m_col),
    .m_last   (m_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected ROM coordinates of the k-th beat in scan order.
  function automatic void exp_rc(input int k, output int r, output int c);
`ifdef MATRIX_TRANSPOSE_EN
    r = k % ROWS;
    c = k / ROWS;
`else
    r = k / COLS;
    c = k % COLS;
`endif
  endfunction

  function automatic int exp_addr(input int k);
    int r, c;
    exp_rc(k, r, c);
    return r * COLS + c;
  endfunction

  function automatic logic next_rand();
    lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    return lfsr[0];
  endfunction

  // Called at posedge+1; leaves the bench at posedge+1 of the edge that sampled start.
  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Consume beats until `stop` handshakes; returns the number of cycles used.
  task automatic stream(input int rmode, input int stop, input bit repulse, output int cycles);
    int beat = 0;
    bit stalled = 0;
    logic [7:0] sd;
    logic [4:0] sr, sc;
    logic sl;
    int r, c;
    cycles = 0;
    m_ready = (rmode == 0) ? 1'b1 : next_rand();
    while (beat < stop && cycles < 8 * N) begin
      @(negedge clk);
      if (done) dones++;
      if (stalled) begin
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_data", 32'(m_data), 32'(sd));
        check("stall_tag", {m_last, 11'd0, m_row, 10'd0, m_col}, {sl, 11'd0, sr, 10'd0, sc});
      end
      if (m_valid && m_ready) begin
        exp_rc(beat, r, c);
        check("data", 32'(m_data), 32'(exp_addr(beat) & 255));
        check("row", 32'(m_row), 32'(r));
        check("col", 32'(m_col), 32'(c));
        check("last", 32'(m_last), 32'(beat == N - 1));
        if (repulse && (beat == 100 || beat == N - 1)) start = 1'b1;
        beat++;
        stalled = 0;
      end else begin
        stalled = m_valid;
        sd = m_data; sr = m_row; sc = m_col; sl = m_last;
      end
      @(posedge clk);
      #1 start = 1'b0;
      cycles++;
      m_ready = (rmode == 0) ? 1'b1 : next_rand();
    end
    check("beats_before_timeout", 32'(beat), 32'(stop));
  endtask

  initial begin
    #23 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(m_valid), 0);
    check("rst_addr", 32'(rom_addr), 0);

    // Full-rate scan with latency checks.
    m_ready = 1'b1;
    do_start();
    check("e0_addr", 32'(rom_addr), 0);
    check("e0_busy", 32'(busy), 1);
    check("e0_valid", 32'(m_valid), 0);
    @(posedge clk); #1;
    check("e1_valid", 32'(m_valid), 0);
    check("e1_addr", 32'(rom_addr), 32'(exp_addr(1)));
    @(posedge clk); #1;
    check("e2_valid", 32'(m_valid), 1);
    dones = 0;
    stream(0, N, 0, cyc);
    check("full_rate_cycles", 32'(cyc), N);
    check("done_pulse", 32'(done), 1);
    check("busy_fall", 32'(busy), 0);
    @(posedge clk); #1;
    check("done_clear", 32'(done), 0);

    // Random back-pressure.
    do_start();
    stream(1, N, 0, cyc);
    check("rand_done", 32'(done), 1);

    // Ready held low: only four reads may be in flight or buffered.
    @(posedge clk); #1;
    m_ready = 1'b0;
    do_start();
    repeat (10) @(posedge clk);
    #1 check("stall_addr_10", 32'(rom_addr), 32'(exp_addr(3)));
    repeat (9) @(posedge clk);
    #1 check("stall_addr_20", 32'(rom_addr), 32'(exp_addr(3)));
    check("stall_head", 32'(m_data), 0);
    check("stall_busy", 32'(busy), 1);
    stream(0, N, 0, cyc);
    check("resume_cycles", 32'(cyc), N);

    // start re-pulsed mid-scan and during the final handshake.
    @(posedge clk); #1;
    m_ready = 1'b1;
    do_start();
    dones = 0;
    stream(0, N, 1, cyc);
    repeat (5) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("single_done", 32'(dones), 1);
    check("no_restart", 32'(busy), 0);
    check("idle_valid", 32'(m_valid), 0);

    // Asynchronous reset mid-scan.
    @(posedge clk); #1;
    do_start();
    stream(0, 500, 0, cyc);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(m_valid), 0);
    check("ar_busy", 32'(busy), 0);
    check("ar_addr", 32'(rom_addr), 0);
    check("ar_data", 32'(m_data), 0);
    check("ar_tags", {m_last, m_row, m_col, done}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_start();
    stream(0, N, 0, cyc);
    check("post_rst_done", 32'(done), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
